// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared definitions for the round-robin MUX arbiter. It holds the
//   arbiter state encoding, the default burst length and a constant
//   clog2 helper. The helper sizes the select and burst-count buses.
package mux_rr_arbiter_pkg;

   localparam int DEFAULT_BURST = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Ceiling log2, usable in parameter and port declarations.
   // The arbiter only calls it with n >= 2.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux_rr_arbiter_mux
//   Data-selection multiplexer. It chooses one WIDTH-bit word out of SEL
//   packed words.
// Ports:
//   in   [SEL*WIDTH]  packed words; word i is at [i*WIDTH +: WIDTH]
//   sel  [clog2(SEL)] index of the word to forward
//   out  [WIDTH]      selected word (zero if sel >= SEL)
module mux_rr_arbiter_mux
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEL   = 4
) (
   input  logic [SEL*WIDTH-1:0]  in,
   input  logic [clog2(SEL)-1:0] sel,
   output logic [WIDTH-1:0]      out
);

   localparam int SW = clog2(SEL);

   // Compare against each legal index. A select value outside the range
   // can then never index past the packed input.
   always_comb begin
      // NOTE: assign a default first, so that every path through the block
      // drives out and no latch is inferred.
      out = '0;
      for (int i = 0; i < SEL; i++) begin
         if (sel == SW'(i)) out = in[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Lets SEL requesters share one WIDTH-bit output stream. Grants are
//   given round-robin. Each grant allows at most BURST transfers. An idle
//   cycle always separates two grants.
//   Optional build macro MUX_ARB_PRIORITY_EN: when it is defined,
//   requester 0 wins every arbitration it takes part in, and its grants do
//   not move the round-robin pointer.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req        [SEL]        per-requester request level
//   in         [SEL*WIDTH]  packed requester data (i at [i*WIDTH +: WIDTH])
//   ack        [SEL]        one-hot pulse: the granted word is consumed
//   out_data   [WIDTH]      data of the granted requester
//   out_valid               out_data is valid
//   out_ready               consumer accepts out_data
//   gnt        [SEL]        one-hot current grant, 0 when idle
//   sel        [clog2(SEL)] encoded grant; holds its value while idle
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEL   = 4,
   parameter int BURST = DEFAULT_BURST
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL-1:0]        req,
   input  logic [SEL*WIDTH-1:0]  in,
   output logic [SEL-1:0]        ack,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL-1:0]        gnt,
   output logic [clog2(SEL)-1:0] sel
);

   localparam int SW = clog2(SEL);
   localparam int CW = clog2(BURST + 1);

   if (BURST < 1) begin : g_bad_burst
      $error("mux_rr_arbiter: BURST must be at least 1");
   end
   if (SEL < 2 || SEL > 32) begin : g_bad_sel
      $error("mux_rr_arbiter: SEL must be in 2..32");
   end

   arb_state_e     state;
   logic [CW-1:0]  cnt;
   logic [SW-1:0]  last;
   logic [SW-1:0]  pick;
   logic           xfer;
   logic           burst_end;

   // Return the first requester after p, wrapping around from SEL-1 to 0.
   // The loop walks from the farthest offset down to the nearest one, so
   // the nearest active requester is the one that remains in pick.
   function automatic logic [SW-1:0] rr_pick(input logic [SEL-1:0] r,
                                              input logic [SW-1:0]  p);
      logic [SW-1:0] res;
      int            idx;
      res = p;
      for (int k = SEL; k >= 1; k--) begin
         idx = (int'(p) + k) % SEL;
         if (r[idx]) res = SW'(idx);
      end
      return res;
   endfunction

`ifdef MUX_ARB_PRIORITY_EN
   assign pick = req[0] ? '0 : rr_pick(req, last);
`else
   assign pick = rr_pick(req, last);
`endif

   // A cycle in which reset is asserted never counts as a transfer. This
   // keeps the consumer from taking a word that would never be acked.
   assign out_valid = !rst && (state == ST_BURST) && req[sel];
   assign xfer      = out_valid && out_ready;
   assign ack       = xfer ? (SEL'(1) << sel) : '0;
   assign burst_end = !req[sel] || (xfer && (cnt == CW'(BURST - 1)));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then updates from values sampled before the clock edge.
      if (rst) begin
         state <= ST_IDLE;
         gnt   <= '0;
         sel   <= '0;
         cnt   <= '0;
         last  <= SW'(SEL - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt   <= SEL'(1) << pick;
                  sel   <= pick;
                  cnt   <= '0;
                  state <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (burst_end) begin
                  state <= ST_IDLE;
                  gnt   <= '0;
                  cnt   <= '0;
`ifdef MUX_ARB_PRIORITY_EN
                  // A priority grant of requester 0 leaves the pointer
                  // where it was.
                  if (sel != '0) last <= sel;
`else
                  last  <= sel;
`endif
               end else if (xfer) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   mux_rr_arbiter_mux #(
      .WIDTH (WIDTH),
      .SEL   (SEL)
   ) u_mux (
      .in  (in),
      .sel (sel),
      .out (out_data)
   );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Self-checking bench for mux_rr_arbiter with SEL=4, WIDTH=8 and BURST=2.
//   The stimulus is built from three parts:
//     - a table of hand-derived vectors,
//     - two hand-written corner-case sequences (a stall and a reset in the
//       middle of a burst),
//     - a random phase.
//   A reference model checks every cycle. The model tracks the current
//   owner, the number of words that owner has moved, and the pointer.
//   Compile with +define+MUX_ARB_PRIORITY_EN to check the priority build.
module tb_mux_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int SEL   = 4;
   localparam int BURST = 2;
`ifdef MUX_ARB_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [SEL-1:0]       req;
   logic [SEL*WIDTH-1:0] din;
   logic [SEL-1:0]       ack;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [SEL-1:0]       gnt;
   logic [1:0]           sel;

   always #5 clk = ~clk;

   mux_rr_arbiter #(
      .WIDTH (WIDTH),
      .SEL   (SEL),
      .BURST (BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in        (din),
      .ack       (ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner is -1 while idle. done counts the words the
   // owner has moved during the current grant.
   int m_owner = -1;
   int m_done  = 0;
   int m_last  = SEL - 1;
   int m_sel   = 0;

   task automatic model_step(input logic [SEL-1:0] r, input logic rdy, input logic rs);
      bit fin;
      if (rs) begin
         m_owner = -1;
         m_done  = 0;
         m_last  = SEL - 1;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         if (r != '0) begin
            if (PRIO && r[0]) begin
               m_owner = 0;
            end else begin
               for (int k = 1; k <= SEL; k++) begin
                  int i;
                  i = (m_last + k) % SEL;
                  if (r[i]) begin
                     m_owner = i;
                     break;
                  end
               end
            end
            m_done = 0;
            m_sel  = m_owner;
         end
      end else begin
         fin = 1'b0;
         if (!r[m_owner]) begin
            fin = 1'b1;
         end else if (rdy) begin
            m_done++;
            if (m_done == BURST) fin = 1'b1;
         end
         if (fin) begin
            if (!(PRIO && m_owner == 0)) m_last = m_owner;
            m_owner = -1;
         end
      end
   endtask

   // Applies one cycle of stimulus, compares the DUT with the model before
   // the next rising edge, and then advances the model across that edge.
   task automatic cycle(input logic [SEL-1:0] r, input logic rdy, input logic rs,
                        input logic [SEL*WIDTH-1:0] d, input bit cmp);
      logic [SEL-1:0] e_gnt;
      logic [SEL-1:0] e_ack;
      logic [1:0]     e_sel;
      logic           e_valid;
      @(negedge clk);
      req       = r;
      out_ready = rdy;
      rst       = rs;
      din       = d;
      #1;
      e_gnt   = (m_owner >= 0) ? SEL'(1 << m_owner) : '0;
      e_sel   = (m_owner >= 0) ? 2'(m_owner) : 2'(m_sel);
      e_valid = !rs && ((r & e_gnt) != '0);
      e_ack   = (e_valid && rdy) ? e_gnt : '0;
      if (cmp) begin
         check("model_gnt",   32'(gnt),       32'(e_gnt));
         check("model_sel",   32'(sel),       32'(e_sel));
         check("model_valid", 32'(out_valid), 32'(e_valid));
         check("model_ack",   32'(ack),       32'(e_ack));
         if (e_valid) check("model_data", 32'(out_data), 32'(d[e_sel*WIDTH +: WIDTH]));
      end
      model_step(r, rdy, rs);
   endtask

   typedef struct {
      bit             chk;
      logic [SEL-1:0] req;
      logic           rdy;
      logic           rst;
      logic [SEL-1:0] gnt;
      logic [1:0]     sel;
      logic           valid;
      logic [SEL-1:0] ack;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit c, input logic [3:0] r, input logic rs,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic [3:0] a);
      vec_t e;
      e.chk = c; e.req = r; e.rdy = 1'b1; e.rst = rs;
      e.gnt = g; e.sel = s; e.valid = v; e.ack = a;
      tbl.push_back(e);
   endtask

   localparam logic [SEL*WIDTH-1:0] FIXED_DATA = 32'hA3A2A1A0;

   initial begin
      logic [SEL-1:0] rq;

      // Reset sequence, followed by ten idle cycles.
      add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'b0000);
      add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'b0000);
      for (int i = 0; i < 10; i++) add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'b0000);
`ifndef MUX_ARB_PRIORITY_EN
      // All requesters busy: grant order 0,1,2,3,0, two acks each, one
      // bubble between grants.
      add(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 4'b0000);
      for (int g = 0; g < 5; g++) begin
         add(1, 4'b1111, 0, 4'(1 << (g % 4)), 2'(g % 4), 1, 4'(1 << (g % 4)));
         add(1, 4'b1111, 0, 4'(1 << (g % 4)), 2'(g % 4), 1, 4'(1 << (g % 4)));
         if (g < 4) add(1, 4'b1111, 0, 4'b0000, 2'(g % 4), 0, 4'b0000);
      end
      // Requester 2 alone: 2 transfers, 1 bubble, repeated.
      add(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 4'b0000);
      for (int rep = 0; rep < 2; rep++) begin
         add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0100);
         add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0100);
         add(1, 4'b0100, 0, 4'b0000, 2'd2, 0, 4'b0000);
      end
      // Requester 1 withdraws after one transfer; requester 2 is next.
      add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'b0000);
      add(1, 4'b0110, 0, 4'b0000, 2'd0, 0, 4'b0000);
      add(1, 4'b0110, 0, 4'b0010, 2'd1, 1, 4'b0010);
      add(1, 4'b0100, 0, 4'b0010, 2'd1, 0, 4'b0000);
      add(1, 4'b0100, 0, 4'b0000, 2'd1, 0, 4'b0000);
      add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0100);
      add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0100);
      add(1, 4'b0000, 0, 4'b0000, 2'd2, 0, 4'b0000);
`else
      // Requester 0 jumps ahead of the pointer without moving it.
      add(1, 4'b1110, 0, 4'b0000, 2'd0, 0, 4'b0000);
      add(1, 4'b1110, 0, 4'b0010, 2'd1, 1, 4'b0010);
      add(1, 4'b1110, 0, 4'b0010, 2'd1, 1, 4'b0010);
      add(1, 4'b1111, 0, 4'b0000, 2'd1, 0, 4'b0000);
      add(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 4'b0001);
      add(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 4'b0001);
      add(1, 4'b1110, 0, 4'b0000, 2'd0, 0, 4'b0000);
      add(1, 4'b1110, 0, 4'b0100, 2'd2, 1, 4'b0100);
      add(1, 4'b1110, 0, 4'b0100, 2'd2, 1, 4'b0100);
      add(1, 4'b1110, 0, 4'b0000, 2'd2, 0, 4'b0000);
      add(1, 4'b1110, 0, 4'b1000, 2'd3, 1, 4'b1000);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].req, tbl[i].rdy, tbl[i].rst, FIXED_DATA, tbl[i].chk);
         if (tbl[i].chk) begin
            check($sformatf("tbl[%0d].gnt", i),   32'(gnt),       32'(tbl[i].gnt));
            check($sformatf("tbl[%0d].sel", i),   32'(sel),       32'(tbl[i].sel));
            check($sformatf("tbl[%0d].valid", i), 32'(out_valid), 32'(tbl[i].valid));
            check($sformatf("tbl[%0d].ack", i),   32'(ack),       32'(tbl[i].ack));
            if (tbl[i].valid)
               check($sformatf("tbl[%0d].data", i), 32'(out_data), 32'(8'hA0 + 8'(tbl[i].sel)));
         end
      end

      // Stall in the middle of a burst: after the first transfer,
      // out_ready stays low for 5 cycles, and exactly one more transfer
      // follows the stall.
      cycle(4'b0000, 1'b1, 1'b1, FIXED_DATA, 0);
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      check("stall_first_ack", 32'(ack), 32'h1);
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 1'b0, 1'b0, FIXED_DATA, 1);
         check("stall_valid", 32'(out_valid), 32'h1);
         check("stall_data",  32'(out_data),  32'hA0);
         check("stall_ack",   32'(ack),       32'h0);
         check("stall_gnt",   32'(gnt),       32'h1);
      end
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      check("stall_resume_ack", 32'(ack), 32'h1);
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      check("stall_burst_done", 32'(gnt), 32'h0);

      // Reset during requester 2's burst: no ack in the reset cycle, all
      // outputs return to their reset values, and requester 0 wins next.
      cycle(4'b0000, 1'b1, 1'b1, FIXED_DATA, 0);
      cycle(4'b0110, 1'b1, 1'b0, FIXED_DATA, 1);
      cycle(4'b0110, 1'b1, 1'b0, FIXED_DATA, 1);
      cycle(4'b0110, 1'b1, 1'b0, FIXED_DATA, 1);
      cycle(4'b0110, 1'b1, 1'b0, FIXED_DATA, 1);
      cycle(4'b0110, 1'b1, 1'b1, FIXED_DATA, 1);
      check("rst_mid_gnt_before", 32'(gnt), 32'h4);
      check("rst_mid_no_ack",     32'(ack), 32'h0);
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      check("rst_after_gnt",   32'(gnt),       32'h0);
      check("rst_after_sel",   32'(sel),       32'h0);
      check("rst_after_valid", 32'(out_valid), 32'h0);
      cycle(4'b1111, 1'b1, 1'b0, FIXED_DATA, 1);
      check("rst_first_grant", 32'(gnt), 32'h1);

      // Random phase. Request bits change only now and then, so bursts
      // can run to their full length.
      rq = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < SEL; b++)
            if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
         cycle(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0),
               {$urandom}, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
